teleport_correction_sequencer: RTL
==================================

# teleport_correction_sequencer

Sequences Bob's Pauli corrections for one teleportation round. It accepts Alice's 2-bit classical measurement over a valid/ready handshake and issues the required gate operations to the Bob correction datapath one at a time: X first, then Z. Each operation waits for an acknowledge and is guarded by a timeout. The block also keeps a shadow copy of Bob's Pauli frame and a round counter. It sits between the measurement/switch front end and the Bob correction unit.

## Interface
- `ACK_TIMEOUT`, default 15: cycles allowed between issuing a gate and receiving `corr_ack`.
- `ROUND_W`, default 8: width of the round counter.

- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-high (asserted = 1), despite the suffix.
- `meas_valid`  in  1  Alice measurement present.
- `meas_bits`  in  2  bit0 = X correction required, bit1 = Z correction required.
- `meas_ready`  out  1  sequencer can accept a measurement.
- `corr_valid`  out  1  gate request to the Bob datapath.
- `corr_op`  out  2  01 = X, 10 = Z, 00 when idle.
- `corr_ack`  in  1  datapath has applied the current gate.
- `done`  out  1  one-cycle pulse when a round completes.
- `bob_frame`  out  2  shadow Pauli frame: bit0 = X, bit1 = Z.
- `round_count`  out  ROUND_W  completed rounds, wraps modulo 2^ROUND_W.
- `error`  out  1  sticky ack-timeout flag.
- `err_clr`  in  1  clears `error` and returns the block to IDLE.

## Operation
- States: IDLE, APPLY_X, APPLY_Z, DONE, ERR.
- IDLE:
  - `meas_ready` = 1.
  - On `meas_valid && meas_ready`, latch `meas_bits`.
  - Next state is APPLY_X if bit0 is set, else APPLY_Z if bit1 is set, else DONE.
- APPLY_X:
  - `corr_valid` = 1, `corr_op` = 01.
  - On `corr_ack`, toggle `bob_frame[0]`.
  - Then go to APPLY_Z if latched bit1 is set, else DONE.
- APPLY_Z:
  - `corr_valid` = 1, `corr_op` = 10.
  - On `corr_ack`, toggle `bob_frame[1]`, then go to DONE.
- DONE:
  - `done` = 1 for exactly one cycle.
  - `round_count` increments (0xFF -> 0x00 at ROUND_W = 8).
  - Next state is IDLE.
- ERR:
  - Entered when the timer reaches ACK_TIMEOUT in either APPLY state with no ack.
  - `error` = 1; `corr_valid`, `meas_ready` and `done` are all 0.
  - The gate that timed out is not applied to `bob_frame`.
  - Stays in ERR until `err_clr`, then goes to IDLE with `error` = 0.
- `err_clr` outside ERR has no effect.
- `corr_ack` while `corr_valid` = 0 is ignored.
- The ack timer resets to 0 on every entry to an APPLY state and counts each cycle without an ack.
- An ack arriving in the same cycle the timer reaches ACK_TIMEOUT wins: the gate is applied and no error is raised.
- `bob_frame` persists across rounds. Only reset clears it.

## Timing
- All outputs are registered or decoded from the registered state.
- Reset values: state IDLE, `meas_ready` = 1, `corr_valid` = 0, `corr_op` = 00, `done` = 0, `bob_frame` = 00, `round_count` = 0, `error` = 0, timer = 0.
- Reset is effective immediately and aborts any round in flight. No partial frame update occurs.
- Handshake accepted at edge N:
  - First `corr_valid` is high in cycle N+1.
  - Measurement 00: `done` is high in cycle N+1.
- An ack sampled at edge M with `corr_valid` high:
  - the next op's `corr_valid` is high in cycle M+1, or
  - `done` is high in cycle M+1 if no op remains.
- Minimum round length (acks returned same-cycle):
  - 00: 2 cycles.
  - 01 or 10: 3 cycles.
  - 11: 4 cycles.
- `meas_ready` is 0 from N+1 until the cycle after DONE. A measurement held valid is not re-accepted until then.
- `corr_op` and `corr_valid` stay stable until acked or timed out.

## Structure
- Package `teleport_pkg`:
  - state enum;
  - op constants `OP_NONE` = 00, `OP_X` = 01, `OP_Z` = 10;
  - frame bit indices (X = 0, Z = 1).
- One sub-module, `ack_timer`:
  - loadable up-counter with `clear`, `enable` and an `expired` flag;
  - parameterised by ACK_TIMEOUT;
  - width derived with `$clog2`.

## Test plan
- Reset and idle:
  - Assert `rst_n` = 1 mid-APPLY_X -> all outputs return to their reset values in the same cycle.
  - Deassert, send 01 -> `corr_op` = 01 one cycle after accept.
- Measurement 11 with acks returned the cycle after valid:
  - ops observed in order 01 then 10;
  - `bob_frame` goes 00 -> 01 -> 11;
  - one `done` pulse;
  - `round_count` = 1.
- Measurement 00 -> `done` one cycle after accept, no `corr_valid`, `bob_frame` unchanged.
- Timeout:
  - Send 10, withhold ack for 15 cycles -> `error` = 1, `corr_valid` = 0, `meas_ready` = 0, `bob_frame[1]` unchanged.
  - Pulse `err_clr` -> IDLE, `error` = 0.
- Timeout boundary: ack exactly at cycle 15 -> gate applied, `error` stays 0.
- Counter wrap: run 256 rounds of 01 -> `round_count` returns to 0; `bob_frame[0]` is back at 0 after an even count.

Source files
------------

// File: rtl/teleport_pkg.sv
// Shared types and constants for the teleportation correction sequencer.
package teleport_pkg;

   typedef enum logic [2:0] {
      IDLE,
      APPLY_X,
      APPLY_Z,
      DONE,
      ERR
   } state_t;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_X    = 2'b01;
   localparam logic [1:0] OP_Z    = 2'b10;

   localparam int FRAME_X = 0;
   localparam int FRAME_Z = 1;

endpackage

// File: rtl/teleport_correction_sequencer_ack_timer.sv
// Ack watchdog: counts cycles spent waiting for a gate acknowledge.
module ack_timer #(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [W-1:0] LIMIT = W'(ACK_TIMEOUT);
   localparam logic [W-1:0] LAST  = W'(ACK_TIMEOUT - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && count != LIMIT) begin
         count <= count + 1'b1;
      end
   end

   // High in the last waiting cycle: an unacked edge here reaches the limit.
   assign expired = enable && (count == LAST);

endmodule

// File: rtl/teleport_correction_sequencer.sv
// Issues Bob's X then Z corrections for one teleportation round.
module teleport_correction_sequencer
   import teleport_pkg::*;
#(
   parameter int ACK_TIMEOUT = 15,
   parameter int ROUND_W     = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               meas_valid,
   input  logic [1:0]         meas_bits,
   output logic               meas_ready,
   output logic               corr_valid,
   output logic [1:0]         corr_op,
   input  logic               corr_ack,
   output logic               done,
   output logic [1:0]         bob_frame,
   output logic [ROUND_W-1:0] round_count,
   output logic               error,
   input  logic               err_clr
);

   state_t state;
   state_t next_state;
   logic   z_pend;
   logic   timer_clear;
   logic   timer_en;
   logic   expired;

   // rst_n is active-high despite its name.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state       <= IDLE;
         z_pend      <= 1'b0;
         bob_frame   <= 2'b00;
         round_count <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && meas_valid) begin
            z_pend <= meas_bits[FRAME_Z];
         end
         if (state == APPLY_X && corr_ack) begin
            bob_frame[FRAME_X] <= ~bob_frame[FRAME_X];
         end
         if (state == APPLY_Z && corr_ack) begin
            bob_frame[FRAME_Z] <= ~bob_frame[FRAME_Z];
         end
         if (state == DONE) begin
            round_count <= round_count + 1'b1;
         end
      end
   end

   always_comb begin
      next_state = state;
      meas_ready = 1'b0;
      corr_valid = 1'b0;
      corr_op    = OP_NONE;
      done       = 1'b0;
      error      = 1'b0;
      unique case (state)
         IDLE: begin
            meas_ready = 1'b1;
            if (meas_valid) begin
               if (meas_bits[FRAME_X]) begin
                  next_state = APPLY_X;
               end else if (meas_bits[FRAME_Z]) begin
                  next_state = APPLY_Z;
               end else begin
                  next_state = DONE;
               end
            end
         end
         APPLY_X: begin
            corr_valid = 1'b1;
            corr_op    = OP_X;
            if (corr_ack) begin
               next_state = z_pend ? APPLY_Z : DONE;
            end else if (expired) begin
               next_state = ERR;
            end
         end
         APPLY_Z: begin
            corr_valid = 1'b1;
            corr_op    = OP_Z;
            if (corr_ack) begin
               next_state = DONE;
            end else if (expired) begin
               next_state = ERR;
            end
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         ERR: begin
            error = 1'b1;
            if (err_clr) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // An ack restarts the timer so the following gate gets a full window.
   assign timer_clear = !corr_valid || corr_ack;
   assign timer_en    = corr_valid && !corr_ack;

   ack_timer #(
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) u_ack_timer (
      .clk    (clk),
      .rst    (rst_n),
      .clear  (timer_clear),
      .enable (timer_en),
      .expired(expired)
   );

endmodule
